// File: rtl/pug_muldiv_xl.sv
// RV32M/RV64M multiply/divide unit: shift-add multiplier (MUL_BITS per cycle),
// restoring divider (1 bit per cycle), single-cycle divide special cases, RV64 *W ops.
module pug_muldiv_xl #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      fn3,
    input  logic            op_w,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rd
);
    localparam int DW = 2 * XLEN;
    localparam logic [2:0] FN_MUL   = 3'd0;
    localparam logic [2:0] FN_MULHU = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_SPEC, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_nx;

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

    logic            accept, w_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, spec_in;
    logic [XLEN-1:0] ones, wmask_in, a_in, b_in, min_in, a_mag_in, b_mag_in;

    assign ones     = '1;
    assign accept   = req_valid && req_ready && !kill;
    assign w_in     = (XLEN == 64) && op_w;
    assign a_sgn_in = fn3[2] ? ~fn3[0] : (fn3 != FN_MULHU);
    assign b_sgn_in = fn3[2] ? ~fn3[0] : ~fn3[1];
    assign a_in     = w_in ? ext32(rs1, a_sgn_in) : rs1;
    assign b_in     = w_in ? ext32(rs2, b_sgn_in) : rs2;
    assign wmask_in = w_in ? (ones >> (XLEN - 32)) : ones;
    assign min_in   = w_in ? (ones << 31) : (ones << (XLEN - 1));
    assign spec_in  = fn3[2] && ((b_in == '0) || (a_sgn_in && (a_in == min_in) && (b_in == ones)));
    assign a_neg_in = a_sgn_in & a_in[XLEN-1];
    assign b_neg_in = b_sgn_in & b_in[XLEN-1];
    assign a_mag_in = neg_if(a_in, a_neg_in);
    assign b_mag_in = neg_if(b_in, b_neg_in);

    logic [2:0]      fn_q;
    logic            w_q, a_sgn_q, b_sgn_q, neg_q_r, neg_r_r;
    logic [XLEN-1:0] a_q, b_q, mplier, rem_r, quo_r, dsr_r, wmask_q, res, fin;
    logic [DW-1:0]   acc, mcand, part, corr, acc_step;
    logic [XLEN:0]   shifted, trial;
    logic [6:0]      cnt, mul_n, div_n;
    logic            a_top, b_top, qbit, fin_now;

    assign wmask_q = w_q ? (ones >> (XLEN - 32)) : ones;
    assign mul_n   = w_q ? 7'(32 / MUL_BITS) : 7'(XLEN / MUL_BITS);
    assign div_n   = w_q ? 7'd32 : 7'(XLEN);
    assign a_top   = w_q ? a_q[31] : a_q[XLEN-1];
    assign b_top   = w_q ? b_q[31] : b_q[XLEN-1];
    assign fin_now = (state == S_SPEC) || ((state == S_MUL) && (cnt == mul_n))
                   || ((state == S_DIV) && (cnt == div_n));

    // Multiplier step: unsigned partial products; signed correction folded into the first step
    always_comb begin
        part = '0;
        for (int j = 0; j < MUL_BITS; j++)
            if (mplier[j]) part = part + (mcand << j);
        corr = '0;
        if (a_sgn_q && a_top) corr = corr + DW'(b_q & wmask_q);
        if (b_sgn_q && b_top) corr = corr + DW'(a_q & wmask_q);
        corr = w_q ? (corr << 32) : (corr << XLEN);
        acc_step = acc + part - ((cnt == 7'd0) ? corr : {DW{1'b0}});
    end

    // Restoring divider step on magnitudes
    assign shifted = {rem_r, quo_r[XLEN-1]};
    assign trial   = shifted - {1'b0, dsr_r};
    assign qbit    = ~trial[XLEN];

    always_comb begin
        res = '0;
        case (state)
            S_SPEC: begin
                if (b_q == '0) res = fn_q[1] ? a_q : ones;
                else           res = fn_q[1] ? '0 : a_q;
            end
            S_MUL: begin
                if (fn_q == FN_MUL) res = acc[XLEN-1:0];
                else                res = w_q ? XLEN'(acc[63:32]) : acc[DW-1:XLEN];
            end
            default: res = fn_q[1] ? neg_if(rem_r, neg_r_r) : neg_if(quo_r, neg_q_r);
        endcase
        fin = w_q ? ext32(res, 1'b1) : res;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE:  req_ready = 1'b1;
            S_DONE:  begin req_ready = 1'b1; rsp_valid = 1'b1; end
            default: busy = 1'b1;
        endcase
        if (kill) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (req_valid) state_nx = spec_in ? S_SPEC : (fn3[2] ? S_DIV : S_MUL);
                S_SPEC:         state_nx = S_DONE;
                S_MUL:          if (cnt == mul_n) state_nx = S_DONE;
                S_DIV:          if (cnt == div_n) state_nx = S_DONE;
                default:        state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                rd <= '0;
        else if (!kill && fin_now) rd <= fin;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fn_q    <= fn3;
            w_q     <= w_in;
            a_sgn_q <= a_sgn_in;
            b_sgn_q <= b_sgn_in;
            a_q     <= a_in;
            b_q     <= b_in;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= DW'(a_in & wmask_in);
            mplier  <= b_in & wmask_in;
            rem_r   <= '0;
            quo_r   <= w_in ? (a_mag_in << (XLEN - 32)) : a_mag_in;
            dsr_r   <= b_mag_in;
            neg_q_r <= a_neg_in ^ b_neg_in;
            neg_r_r <= a_neg_in;
        end else if ((state == S_MUL) && (cnt != mul_n)) begin
            acc    <= acc_step;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt + 7'd1;
        end else if ((state == S_DIV) && (cnt != div_n)) begin
            rem_r <= qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], qbit};
            cnt   <= cnt + 7'd1;
        end
    end
endmodule
